// File: rtl/mult8_ctrl_pkg.sv
// Shared encodings for the 8x8 multiplier sequencing controller.
package mult8_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SHIFT_0   = 2'd0;
  localparam logic [1:0] SHIFT_4   = 2'd1;
  localparam logic [1:0] SHIFT_8   = 2'd2;
  localparam logic [1:0] LAST_STEP = 2'd3;

endpackage

// File: rtl/mult8_ctrl_if.sv
// Handshake plus datapath-steering bundle between the controller and its surroundings.
interface mult8_ctrl_if;

  logic       start;
  logic       a_sel;
  logic       b_sel;
  logic [1:0] shift_sel;
  logic       acc_clk_en;
  logic       acc_sclr_n;
  logic       busy;
  logic       done;
  logic       overrun;
  logic [1:0] state_out;

  modport slave (
    input  start,
    output a_sel, b_sel, shift_sel, acc_clk_en, acc_sclr_n,
    output busy, done, overrun, state_out
  );

  modport master (
    output start,
    input  a_sel, b_sel, shift_sel, acc_clk_en, acc_sclr_n,
    input  busy, done, overrun, state_out
  );

endinterface

// File: rtl/mult8_ctrl_step_cnt.sv
// 2-bit partial-product step counter: async active-low reset, sync clear over enable,
// terminal count at LAST_STEP.
module step_cnt
  import mult8_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [1:0] cnt_o,
  output logic       tc_o
);

  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST_STEP);

endmodule

// File: rtl/mult8_ctrl.sv
// Sequencer time-sharing one 4x4 multiplier over four partial products into a
// 16-bit accumulator; Moore outputs, registered sticky overrun.
module mult8_ctrl
  import mult8_ctrl_pkg::*;
#(
  parameter bit AUTO_CLR = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  mult8_ctrl_if.slave  bus
);

  // Where an accepted start lands: CLR normally, straight into CALC when accumulating.
  localparam state_t START_ST = AUTO_CLR ? CLR : CALC;

  state_t     state_q, state_d;
  logic       overrun_q, overrun_d;
  logic       accept;
  logic [1:0] step;
  logic       step_tc;

  step_cnt u_step (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (state_q != CALC),
    .en_i  (state_q == CALC),
    .cnt_o (step),
    .tc_o  (step_tc)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = START_ST;
        accept  = 1'b1;
      end
      CLR:  state_d = CALC;
      CALC: if (step_tc) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = START_ST;
          accept  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.start && (state_q == CLR || state_q == CALC)) overrun_d = 1'b1;
    if (accept) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    bus.a_sel      = 1'b0;
    bus.b_sel      = 1'b0;
    bus.shift_sel  = SHIFT_0;
    bus.acc_clk_en = 1'b0;
    bus.acc_sclr_n = 1'b1;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    case (state_q)
      CLR: begin
        bus.acc_clk_en = 1'b1;
        bus.acc_sclr_n = 1'b0;
        bus.busy       = 1'b1;
      end
      CALC: begin
        bus.acc_clk_en = 1'b1;
        bus.busy       = 1'b1;
        bus.a_sel      = step[1];
        bus.b_sel      = step[0];
        case (step)
          2'd0:    bus.shift_sel = SHIFT_0;
          2'd3:    bus.shift_sel = SHIFT_8;
          default: bus.shift_sel = SHIFT_4;
        endcase
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.overrun   = overrun_q;
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_mult8_ctrl.sv
// Scoreboard bench: two controllers (AUTO_CLR=1 and 0) each driving a behavioural
// 4x4-multiplier/accumulator datapath; expected observations are queued per cycle.
module tb_mult8_ctrl;
  import mult8_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mult8_ctrl_if ifa ();
  mult8_ctrl_if ifb ();

  mult8_ctrl #(.AUTO_CLR(1'b1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  mult8_ctrl #(.AUTO_CLR(1'b0)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

  // Datapath models: nibble muxes, 4x4 multiplier, shifter, 16-bit accumulator.
  logic [7:0]  a_opa = 8'h00, a_opb = 8'h00, b_opa = 8'h00, b_opb = 8'h00;
  logic [15:0] acc_a = 16'h0000, acc_b = 16'h0000;

  function automatic logic [15:0] pp(input logic [7:0] x, input logic [7:0] y,
                                     input logic xs, input logic ys, input logic [1:0] sh);
    logic [3:0] nx, ny;
    logic [7:0] m;
    nx = xs ? x[7:4] : x[3:0];
    ny = ys ? y[7:4] : y[3:0];
    m  = nx * ny;
    return {8'h00, m} << (4 * sh);
  endfunction

  always @(posedge clk) begin
    if (ifa.acc_clk_en)
      acc_a <= !ifa.acc_sclr_n ? 16'h0000
             : acc_a + pp(a_opa, a_opb, ifa.a_sel, ifa.b_sel, ifa.shift_sel);
    if (ifb.acc_clk_en)
      acc_b <= !ifb.acc_sclr_n ? 16'h0000
             : acc_b + pp(b_opa, b_opb, ifb.a_sel, ifb.b_sel, ifb.shift_sel);
  end

  // {state, a_sel, b_sel, shift, clk_en, sclr_n, busy, done, overrun, acc}
  logic [26:0] obs_a, obs_b;
  assign obs_a = {ifa.state_out, ifa.a_sel, ifa.b_sel, ifa.shift_sel, ifa.acc_clk_en,
                  ifa.acc_sclr_n, ifa.busy, ifa.done, ifa.overrun, acc_a};
  assign obs_b = {ifb.state_out, ifb.a_sel, ifb.b_sel, ifb.shift_sel, ifb.acc_clk_en,
                  ifb.acc_sclr_n, ifb.busy, ifb.done, ifb.overrun, acc_b};

  typedef struct {
    int          cyc;
    bit          dut;
    logic [26:0] val;
    logic [26:0] mask;
    string       name;
  } exp_t;

  exp_t sb[$];

  // ovr/acc < 0 means "not checked in this entry".
  function automatic void push(input int c, input bit d, input state_t st, input int step,
                               input int ovr, input int acc, input string nm);
    exp_t e;
    logic [1:0] sh;
    e.cyc  = c;
    e.dut  = d;
    e.name = nm;
    e.val  = '0;
    e.mask = '0;
    e.val[26:25]  = st;
    e.mask[26:17] = '1;
    case (st)
      IDLE: e.val[20:17] = 4'b0100;
      CLR:  e.val[20:17] = 4'b1010;
      CALC: e.val[20:17] = 4'b1110;
      DONE: e.val[20:17] = 4'b0101;
      default: ;
    endcase
    if (st == CLR || st == DONE) e.mask[24:21] = '0;
    if (st == CALC) begin
      sh = (step == 0) ? SHIFT_0 : (step == 3) ? SHIFT_8 : SHIFT_4;
      e.val[24] = (step >= 2);
      e.val[23] = (step % 2 == 1);
      e.val[22:21] = sh;
    end
    if (ovr >= 0) begin
      e.val[16]  = ovr[0];
      e.mask[16] = 1'b1;
    end
    if (acc >= 0) begin
      e.val[15:0]  = acc[15:0];
      e.mask[15:0] = '1;
    end
    sb.push_back(e);
  endfunction

  // One multiply whose start was driven just after edge k.
  function automatic void exp_mult(input bit d, input int k, input logic [15:0] res,
                                   input bit idle_after);
    int c;
    c = k + 1;
    if (d == 1'b0) begin
      push(c, d, CLR, 0, -1, -1, "clr");
      c++;
    end
    for (int s = 0; s < 4; s++) push(c + s, d, CALC, s, -1, -1, "calc");
    c += 4;
    push(c, d, DONE, 0, -1, int'(res), "done_result");
    if (idle_after) push(c + 1, d, IDLE, 0, -1, -1, "idle_after");
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [26:0] got;
        got = sb[i].dut ? obs_b : obs_a;
        checks++;
        if (sb[i].cyc < cyc) begin
          errors++;
          $display("FAIL %s dut%0d cyc %0d: entry missed at cyc %0d", sb[i].name,
                   sb[i].dut, sb[i].cyc, cyc);
        end else if ((got & sb[i].mask) !== (sb[i].val & sb[i].mask)) begin
          errors++;
          $display("FAIL %s dut%0d cyc %0d: got %h expected %h (mask %h)", sb[i].name,
                   sb[i].dut, cyc, got & sb[i].mask, sb[i].val & sb[i].mask, sb[i].mask);
        end
        sb.delete(i);
      end
    end
  end

  task automatic go(input bit d, output int k);
    @(posedge clk);
    #1;
    k = cyc;
    if (d) ifb.start = 1'b1;
    else   ifa.start = 1'b1;
    @(posedge clk);
    #1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  int k;

  initial begin
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      push(c, 1'b0, IDLE, 0, 0, -1, "reset_state");
      push(c, 1'b1, IDLE, 0, 0, -1, "reset_state");
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single multiply with full trace.
    a_opa = 8'h12; a_opb = 8'h34;
    go(1'b0, k);
    exp_mult(1'b0, k, 16'h03A8, 1'b1);
    push(k + 6, 1'b0, DONE, 0, 0, -1, "no_overrun");
    repeat (8) @(posedge clk);

    a_opa = 8'hFF; a_opb = 8'hFF;
    go(1'b0, k);
    exp_mult(1'b0, k, 16'hFE01, 1'b1);
    repeat (8) @(posedge clk);

    a_opa = 8'h00; a_opb = 8'hA5;
    go(1'b0, k);
    exp_mult(1'b0, k, 16'h0000, 1'b1);
    repeat (8) @(posedge clk);

    // Start during CALC is ignored and flags overrun.
    a_opa = 8'h12; a_opb = 8'h34;
    go(1'b0, k);
    exp_mult(1'b0, k, 16'h03A8, 1'b1);
    @(posedge clk);
    #1 ifa.start = 1'b1;
    @(posedge clk);
    #1 ifa.start = 1'b0;
    push(k + 3, 1'b0, CALC, 1, 1, -1, "overrun_set");
    push(k + 6, 1'b0, DONE, 0, 1, -1, "overrun_at_done");
    push(k + 7, 1'b0, IDLE, 0, 1, -1, "overrun_sticky");
    repeat (8) @(posedge clk);
    a_opa = 8'h00; a_opb = 8'hA5;
    go(1'b0, k);
    exp_mult(1'b0, k, 16'h0000, 1'b1);
    push(k + 1, 1'b0, CLR, 0, 0, -1, "overrun_cleared");
    repeat (8) @(posedge clk);

    // Start held high: back-to-back multiplies every 6 cycles.
    a_opa = 8'hFF; a_opb = 8'hFF;
    @(posedge clk);
    #1;
    k = cyc;
    ifa.start = 1'b1;
    exp_mult(1'b0, k,      16'hFE01, 1'b0);
    exp_mult(1'b0, k + 6,  16'hFE01, 1'b0);
    exp_mult(1'b0, k + 12, 16'hFE01, 1'b1);
    repeat (13) @(posedge clk);
    #1 ifa.start = 1'b0;
    repeat (8) @(posedge clk);

    // Asynchronous reset at CALC step 2: immediate IDLE, no done pulse.
    a_opa = 8'h12; a_opb = 8'h34;
    go(1'b0, k);
    push(k + 1, 1'b0, CLR, 0, -1, -1, "pre_reset_clr");
    push(k + 2, 1'b0, CALC, 0, -1, -1, "pre_reset_calc");
    push(k + 3, 1'b0, CALC, 1, -1, -1, "pre_reset_calc");
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    for (int c = k + 4; c <= k + 8; c++) push(c, 1'b0, IDLE, 0, 0, -1, "reset_mid_calc");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) @(posedge clk);

    // AUTO_CLR=0: results accumulate, 5-cycle latency.
    b_opa = 8'h10; b_opb = 8'h10;
    go(1'b1, k);
    exp_mult(1'b1, k, 16'h0100, 1'b1);
    repeat (7) @(posedge clk);
    b_opa = 8'h01; b_opb = 8'h01;
    go(1'b1, k);
    exp_mult(1'b1, k, 16'h0101, 1'b1);
    repeat (10) @(posedge clk);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult8_ctrl.md
# mult8_ctrl

Sequencing controller for the 8x8 multiplier datapath. It time-shares one 4x4 multiplier over four partial products. On each step it steers the nibble-select muxes and the product shifter, and drives the clock-enable and synchronous-clear inputs of the 16-bit accumulator register. It sits beside the datapath and exposes a start/busy/done handshake to the surrounding logic.

## Interface
- `AUTO_CLR`, default 1: 1 = accumulator is cleared before every multiply; 0 = CLR state is skipped and the accumulator sums onto its previous content.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a multiply; sampled in IDLE and DONE only.
- `a_sel`  out  1  dataa nibble select: 0 = [3:0], 1 = [7:4].
- `b_sel`  out  1  datab nibble select: 0 = [3:0], 1 = [7:4].
- `shift_sel`  out  2  product shift: 0 = <<0, 1 = <<4, 2 = <<8; 3 is never driven.
- `acc_clk_en`  out  1  accumulator clock enable.
- `acc_sclr_n`  out  1  accumulator synchronous clear, active-low; effective only with `acc_clk_en`=1.
- `busy`  out  1  high from CLR through the last partial-product step.
- `done`  out  1  one-cycle pulse; the accumulator holds the final product.
- `overrun`  out  1  sticky: `start` was seen while busy.
- `state_out`  out  2  current state code, for debug and the display.

## Operation
- States: IDLE=0, CLR=1, CALC=2, DONE=3. A 2-bit step counter `step` is used inside CALC.
- Outputs are Moore-decoded from the state/step registers, except `overrun`, which is a register.
- IDLE:
  - With `start`=1, go to CLR (or to CALC with `step`=0 if `AUTO_CLR`=0). Otherwise stay.
  - Outputs: `acc_clk_en`=0, `acc_sclr_n`=1, selects and `shift_sel`=0.
- CLR: `acc_clk_en`=1, `acc_sclr_n`=0, `busy`=1. Next state is CALC with `step`=0.
- CALC: `acc_clk_en`=1, `acc_sclr_n`=1, `busy`=1. One partial product per cycle:
  - step 0: `a_sel`=0, `b_sel`=0, `shift_sel`=0
  - step 1: `a_sel`=0, `b_sel`=1, `shift_sel`=1
  - step 2: `a_sel`=1, `b_sel`=0, `shift_sel`=1
  - step 3: `a_sel`=1, `b_sel`=1, `shift_sel`=2
  - `step` increments each cycle. At step 3, go to DONE and set `step` to 0.
- DONE: `done`=1, `acc_clk_en`=0. With `start`=1, go directly to CLR (back-to-back). Otherwise go to IDLE.
- `overrun`: set when `start`=1 in CLR or CALC, and that `start` is ignored. Cleared on the cycle a new `start` is accepted (the accept wins over a simultaneous set).
- Width rule: the datapath sum of the shifted 8-bit partial product and the 16-bit accumulator wraps at 16 bits. Max result 0xFF×0xFF = 0xFE01, so no overflow is possible.

## Timing
- Reset (asynchronous, any time, including mid-multiply):
  - State returns to IDLE and `step`=0.
  - Outputs go to `a_sel`=`b_sel`=0, `shift_sel`=0, `acc_clk_en`=0, `acc_sclr_n`=1, `busy`=0, `done`=0, `overrun`=0, `state_out`=0.
  - Accumulator contents are undefined until the next CLR.
- Latency: with `start` high at edge E0 in IDLE:
  - CLR during E0–E1.
  - CALC steps during E1–E5.
  - DONE during E5–E6.
  - The result is valid on the accumulator output from E5 and stable while not busy.
  - Total: 6 cycles start-to-done (5 with `AUTO_CLR`=0).
- Back-to-back: `start` held high from DONE gives a new CLR in the next cycle, i.e. one multiply every 6 cycles.
- Operands `dataa`/`datab` must be stable from the `start` edge through the last CALC cycle. The controller does not latch them.

## Structure
- Package `mult8_ctrl_pkg` holds:
  - state encoding constants (IDLE/CLR/CALC/DONE)
  - shift codes SHIFT_0/SHIFT_4/SHIFT_8
  - step count constant LAST_STEP=3
- One sub-module, `step_cnt`: a 2-bit counter with asynchronous active-low reset, synchronous clear, enable, and a terminal-count output. The FSM uses its terminal count to leave CALC.

## Test plan
- Reset mid-CALC (assert `reset_n`=0 at step 2) -> all outputs go to their reset values immediately, `state_out`=0, and there is no `done` pulse.
- Single multiply, `start` for 1 cycle -> `state_out` sequence 0,1,2,2,2,2,3,0. `a_sel`/`b_sel`/`shift_sel` per step are 00/0, 01/1, 10/1, 11/2. `done` high exactly 1 cycle, 6 edges after `start`.
- With the datapath model: 0xFF×0xFF -> 0xFE01; 0x12×0x34 -> 0x03A8; 0x00×0xA5 -> 0x0000. Each value is checked on the `done` cycle.
- `start` pulsed during CALC -> ignored; `overrun`=1, and the result and timing are unchanged. The next accepted `start` clears `overrun`.
- `start` held high continuously -> consecutive `done` pulses 6 cycles apart, with CLR immediately after each DONE.
- `AUTO_CLR`=0: two multiplies 0x10×0x10 then 0x01×0x01 -> the accumulator reads 0x0100, then 0x0101. Latency is 5 cycles.
